// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard and sequencing controller for a 5-stage MIPS pipeline.
// Produces per-stage stall/flush controls and Decode operand forwarding
// selects, sequences the multi-cycle mul/div unit, and counts stall cycles.
module pipe_ctrl #(
  parameter int          MULT_CYCLES    = 4,
  parameter int          DIV_CYCLES     = 32,
  // Reset value of the stall counter (normally 0)
  parameter logic [31:0] STALL_CNT_INIT = 32'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  d_rs,
  input  logic [4:0]  d_rt,
  input  logic        d_use_rs,
  input  logic        d_use_rt,
  input  logic [4:0]  e_rd,
  input  logic [4:0]  m_rd,
  input  logic [4:0]  w_rd,
  input  logic        e_reg_write,
  input  logic        m_reg_write,
  input  logic        w_reg_write,
  input  logic        e_memtoreg,
  input  logic        m_memtoreg,
  input  logic        i_busy,
  input  logic        d_busy,
  input  logic        e_md_start,
  input  logic        e_md_is_div,
  output logic        stall_f,
  output logic        stall_d,
  output logic        stall_e,
  output logic        stall_m,
  output logic        flush_d,
  output logic        flush_e,
  output logic        flush_m,
  output logic        flush_w,
  output logic [1:0]  fwd_rs,
  output logic [1:0]  fwd_rt,
  output logic        md_busy,
  output logic        md_done,
  output logic [31:0] stall_cycles
);

  localparam int MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES);

  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_E  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;
  localparam logic [1:0] FWD_W  = 2'b11;

  // A source matches a stage when it is really read, is not r0, and the
  // stage writes that same register.
  function automatic logic src_match(input logic use_src, input logic [4:0] src,
                                     input logic wr, input logic [4:0] rd);
    return use_src && (src != 5'd0) && wr && (rd == src);
  endfunction

  // Nearest non-load producer wins; W is always forwardable.
  function automatic logic [1:0] fwd_sel(input logic me, input logic mm, input logic mw,
                                         input logic e_ld, input logic m_ld);
    logic [1:0] sel;
    if (me && !e_ld) begin
      sel = FWD_E;
    end else if (mm && !m_ld) begin
      sel = FWD_M;
    end else if (mw) begin
      sel = FWD_W;
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

  logic          rs_e_s, rs_m_s, rs_w_s;
  logic          rt_e_s, rt_m_s, rt_w_s;
  logic          load_hz_s;
  logic [1:0]    state_r, state_nxt_s;
  logic [CW-1:0] cnt_r, cnt_nxt_s;
  logic          done_nxt_s;
  logic          md_busy_r, md_done_r;
  logic [31:0]   stall_cnt_r;

  assign rs_e_s = src_match(d_use_rs, d_rs, e_reg_write, e_rd);
  assign rs_m_s = src_match(d_use_rs, d_rs, m_reg_write, m_rd);
  assign rs_w_s = src_match(d_use_rs, d_rs, w_reg_write, w_rd);
  assign rt_e_s = src_match(d_use_rt, d_rt, e_reg_write, e_rd);
  assign rt_m_s = src_match(d_use_rt, d_rt, m_reg_write, m_rd);
  assign rt_w_s = src_match(d_use_rt, d_rt, w_reg_write, w_rd);

  // A load in M only counts when E does not already supply a newer value.
  assign load_hz_s = (rs_e_s && e_memtoreg) || (rs_m_s && m_memtoreg && !rs_e_s) ||
                     (rt_e_s && e_memtoreg) || (rt_m_s && m_memtoreg && !rt_e_s);

  // Operand forwarding selects, forced to regfile while in reset.
  always_comb begin
    fwd_rs = FWD_RF;
    fwd_rt = FWD_RF;
    if (reset) begin
      fwd_rs = FWD_RF;
      fwd_rt = FWD_RF;
    end else begin
      fwd_rs = fwd_sel(rs_e_s, rs_m_s, rs_w_s, e_memtoreg, m_memtoreg);
      fwd_rt = fwd_sel(rt_e_s, rt_m_s, rt_w_s, e_memtoreg, m_memtoreg);
    end
  end

  // Prioritised stall/flush generation; higher conditions mask lower ones.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_m = 1'b0;
    flush_w = 1'b0;
    if (reset) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
      flush_m = 1'b1;
      flush_w = 1'b1;
    end else if (d_busy) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
    end else if (md_busy_r) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      flush_m = 1'b1;
    end else if (load_hz_s || i_busy) begin
      // Holding D also keeps a branch there until its delay slot arrives.
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end else begin
      stall_f = 1'b0;
    end
  end

  // Mul/div sequencer next-state: count down in BUSY, wait in DONE until E moves.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    done_nxt_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (e_md_start) begin
          state_nxt_s = ST_BUSY;
          cnt_nxt_s   = e_md_is_div ? DIV_LOAD : MULT_LOAD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (cnt_r == CNT_ZERO) begin
          state_nxt_s = ST_DONE;
        end else begin
          cnt_nxt_s  = cnt_r - CNT_ONE;
          // md_done is registered, so raise it on the edge entering cnt = 0.
          done_nxt_s = (cnt_r == CNT_ONE);
        end
      end
      ST_DONE: begin
        if (!stall_e) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  // Mul/div sequencer state and its registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      cnt_r     <= CNT_ZERO;
      md_busy_r <= 1'b0;
      md_done_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      md_busy_r <= (state_nxt_s == ST_BUSY);
      md_done_r <= done_nxt_s;
    end
  end

  // Free-running stall-cycle counter, wraps naturally at 2^32.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_r <= STALL_CNT_INIT;
    end else if (stall_f) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign md_busy      = md_busy_r;
  assign md_done      = md_done_r;
  assign stall_cycles = stall_cnt_r;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed-vector bench for pipe_ctrl with hand-computed
// expectations. A second instance starts its stall counter just below the
// wrap point and sees the same stimulus.
module tb_pipe_ctrl;

  logic        clk, reset;
  logic [4:0]  d_rs, d_rt, e_rd, m_rd, w_rd;
  logic        d_use_rs, d_use_rt;
  logic        e_reg_write, m_reg_write, w_reg_write;
  logic        e_memtoreg, m_memtoreg;
  logic        i_busy, d_busy, e_md_start, e_md_is_div;
  logic        stall_f, stall_d, stall_e, stall_m;
  logic        flush_d, flush_e, flush_m, flush_w;
  logic [1:0]  fwd_rs, fwd_rt;
  logic        md_busy, md_done;
  logic [31:0] stall_cycles;
  logic        x_stall_f, x_stall_d, x_stall_e, x_stall_m;
  logic        x_flush_d, x_flush_e, x_flush_m, x_flush_w;
  logic [1:0]  x_fwd_rs, x_fwd_rt;
  logic        x_md_busy, x_md_done;
  logic [31:0] x_stall_cycles;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt;

  pipe_ctrl #(.MULT_CYCLES(4), .DIV_CYCLES(32)) dut (
    .clk(clk), .reset(reset), .d_rs(d_rs), .d_rt(d_rt),
    .d_use_rs(d_use_rs), .d_use_rt(d_use_rt),
    .e_rd(e_rd), .m_rd(m_rd), .w_rd(w_rd),
    .e_reg_write(e_reg_write), .m_reg_write(m_reg_write), .w_reg_write(w_reg_write),
    .e_memtoreg(e_memtoreg), .m_memtoreg(m_memtoreg),
    .i_busy(i_busy), .d_busy(d_busy), .e_md_start(e_md_start), .e_md_is_div(e_md_is_div),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m), .flush_w(flush_w),
    .fwd_rs(fwd_rs), .fwd_rt(fwd_rt), .md_busy(md_busy), .md_done(md_done),
    .stall_cycles(stall_cycles)
  );

  pipe_ctrl #(.MULT_CYCLES(4), .DIV_CYCLES(32), .STALL_CNT_INIT(32'hFFFF_FFFE)) dut_wrap (
    .clk(clk), .reset(reset), .d_rs(d_rs), .d_rt(d_rt),
    .d_use_rs(d_use_rs), .d_use_rt(d_use_rt),
    .e_rd(e_rd), .m_rd(m_rd), .w_rd(w_rd),
    .e_reg_write(e_reg_write), .m_reg_write(m_reg_write), .w_reg_write(w_reg_write),
    .e_memtoreg(e_memtoreg), .m_memtoreg(m_memtoreg),
    .i_busy(i_busy), .d_busy(d_busy), .e_md_start(e_md_start), .e_md_is_div(e_md_is_div),
    .stall_f(x_stall_f), .stall_d(x_stall_d), .stall_e(x_stall_e), .stall_m(x_stall_m),
    .flush_d(x_flush_d), .flush_e(x_flush_e), .flush_m(x_flush_m), .flush_w(x_flush_w),
    .fwd_rs(x_fwd_rs), .fwd_rt(x_fwd_rt), .md_busy(x_md_busy), .md_done(x_md_done),
    .stall_cycles(x_stall_cycles)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_in();
    d_rs = 5'd0; d_rt = 5'd0; d_use_rs = 1'b0; d_use_rt = 1'b0;
    e_rd = 5'd0; m_rd = 5'd0; w_rd = 5'd0;
    e_reg_write = 1'b0; m_reg_write = 1'b0; w_reg_write = 1'b0;
    e_memtoreg = 1'b0; m_memtoreg = 1'b0;
    i_busy = 1'b0; d_busy = 1'b0; e_md_start = 1'b0; e_md_is_div = 1'b0;
  endtask

  task automatic check_ctl(input string tag, input logic [3:0] st, input logic [3:0] fl);
    check_eq({tag, "_stall"}, {28'd0, stall_f, stall_d, stall_e, stall_m}, {28'd0, st});
    check_eq({tag, "_flush"}, {28'd0, flush_d, flush_e, flush_m, flush_w}, {28'd0, fl});
  endtask

  initial begin
    // ---------------- reset state ----------------
    clear_in();
    reset = 1'b1;
    i_busy = 1'b1; d_busy = 1'b1;
    e_reg_write = 1'b1; e_rd = 5'd5; d_rs = 5'd5; d_use_rs = 1'b1;
    #2;
    check_ctl("rst", 4'b0000, 4'b1111);
    check_eq("rst_fwd_rs", {30'd0, fwd_rs}, 32'd0);
    check_eq("rst_md_busy", {31'd0, md_busy}, 32'd0);
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_md_done", {31'd0, md_done}, 32'd0);
    check_eq("rst_cnt", stall_cycles, 32'd0);
    check_eq("rst_cnt_wrap", x_stall_cycles, 32'hFFFF_FFFE);
    @(negedge clk);
    reset = 1'b0;
    clear_in();

    // ---------------- forwarding ----------------
    e_reg_write = 1'b1; e_rd = 5'd5; d_rs = 5'd5; d_use_rs = 1'b1;
    #1;
    check_eq("alu_fwd_rs_e", {30'd0, fwd_rs}, 32'd1);
    check_ctl("alu", 4'b0000, 4'b0000);
    e_rd = 5'd0; d_rs = 5'd0;
    #1;
    check_eq("alu_r0", {30'd0, fwd_rs}, 32'd0);
    e_rd = 5'd5; d_rs = 5'd5; m_reg_write = 1'b1; m_rd = 5'd5;
    #1;
    check_eq("prio_e_over_m", {30'd0, fwd_rs}, 32'd1);
    d_use_rs = 1'b0;
    #1;
    check_eq("use_rs_off", {30'd0, fwd_rs}, 32'd0);
    clear_in();
    m_reg_write = 1'b1; m_rd = 5'd7; d_rt = 5'd7; d_use_rt = 1'b1;
    #1;
    check_eq("fwd_rt_m", {30'd0, fwd_rt}, 32'd2);
    // M load shadowed by a newer non-load producer in E: forward, no stall
    m_memtoreg = 1'b1; e_reg_write = 1'b1; e_rd = 5'd7;
    #1;
    check_eq("m_load_shadowed", {30'd0, fwd_rt}, 32'd1);
    check_ctl("m_load_shadowed", 4'b0000, 4'b0000);
    @(negedge clk);
    clear_in();

    // ---------------- load-use ----------------
    e_reg_write = 1'b1; e_memtoreg = 1'b1; e_rd = 5'd3; d_rt = 5'd3; d_use_rt = 1'b1;
    #1;
    check_ctl("lu_e", 4'b1100, 4'b0100);
    check_eq("lu_cnt0", stall_cycles, 32'd0);
    @(negedge clk);
    e_reg_write = 1'b0; e_memtoreg = 1'b0;
    m_reg_write = 1'b1; m_memtoreg = 1'b1; m_rd = 5'd3;
    #1;
    check_ctl("lu_m", 4'b1100, 4'b0100);
    check_eq("lu_cnt1", stall_cycles, 32'd1);
    check_eq("wrap_ffff", x_stall_cycles, 32'hFFFF_FFFF);
    @(negedge clk);
    m_reg_write = 1'b0; m_memtoreg = 1'b0; w_reg_write = 1'b1; w_rd = 5'd3;
    #1;
    check_eq("lu_fwd_w", {30'd0, fwd_rt}, 32'd3);
    check_ctl("lu_w", 4'b0000, 4'b0000);
    check_eq("lu_cnt2", stall_cycles, 32'd2);
    check_eq("wrap_zero", x_stall_cycles, 32'd0);
    @(negedge clk);
    clear_in();

    // ---------------- multiply (md_busy masks a load hazard) ----------------
    e_md_start = 1'b1;
    #1;
    check_eq("mul_start_busy", {31'd0, md_busy}, 32'd0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      e_reg_write = 1'b1; e_memtoreg = 1'b1; e_rd = 5'd3; d_rt = 5'd3; d_use_rt = 1'b1;
      #1;
      check_eq($sformatf("mul_busy%0d", i), {31'd0, md_busy}, 32'd1);
      check_eq($sformatf("mul_done%0d", i), {31'd0, md_done}, (i == 4) ? 32'd1 : 32'd0);
      check_ctl($sformatf("mul%0d", i), 4'b1110, 4'b0010);
    end
    @(negedge clk);
    clear_in();
    e_md_start = 1'b1;
    #1;
    check_eq("mul_done_st_busy", {31'd0, md_busy}, 32'd0);
    check_eq("mul_done_st_done", {31'd0, md_done}, 32'd0);
    check_ctl("mul_done_st", 4'b0000, 4'b0000);
    check_eq("mul_cnt", stall_cycles, 32'd6);
    @(negedge clk);
    e_md_start = 1'b0;
    #1;
    check_eq("mul_idle_a", {31'd0, md_busy}, 32'd0);
    @(negedge clk);
    #1;
    check_eq("mul_idle_b", {31'd0, md_busy}, 32'd0);

    // ---------------- divide with d_busy over the end ----------------
    e_md_start = 1'b1; e_md_is_div = 1'b1;
    done_cnt = 0;
    for (int i = 1; i <= 36; i++) begin
      @(negedge clk);
      d_busy = (i >= 32 && i <= 34);
      e_md_start = (i <= 35);
      #1;
      if (md_done === 1'b1) done_cnt++;
      check_eq($sformatf("div_busy%0d", i), {31'd0, md_busy}, (i <= 32) ? 32'd1 : 32'd0);
      check_eq($sformatf("div_done%0d", i), {31'd0, md_done}, (i == 32) ? 32'd1 : 32'd0);
      if (i <= 31)
        check_ctl($sformatf("div%0d", i), 4'b1110, 4'b0010);
      else if (i <= 34)
        check_ctl($sformatf("div%0d", i), 4'b1111, 4'b0001);
      else
        check_ctl($sformatf("div%0d", i), 4'b0000, 4'b0000);
    end
    check_eq("div_done_pulses", done_cnt, 32'd1);
    check_eq("div_cnt", stall_cycles, 32'd40);
    clear_in();

    // ---------------- priority and counting ----------------
    i_busy = 1'b1; d_busy = 1'b1;
    #1;
    check_ctl("prio_dbusy", 4'b1111, 4'b0001);
    repeat (3) @(negedge clk);
    #1;
    check_eq("prio_cnt", stall_cycles, 32'd43);
    d_busy = 1'b0;
    #1;
    check_ctl("prio_ibusy", 4'b1100, 4'b0100);
    @(negedge clk);
    clear_in();
    #1;
    check_eq("prio_cnt2", stall_cycles, 32'd44);
    check_eq("prio_cnt2_wrap", x_stall_cycles, 32'd42);

    // ---------------- reset mid-divide ----------------
    @(negedge clk);
    e_md_start = 1'b1; e_md_is_div = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    check_eq("mid_div_busy", {31'd0, md_busy}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check_eq("rst_mid_busy", {31'd0, md_busy}, 32'd0);
    check_ctl("rst_mid", 4'b0000, 4'b1111);
    check_eq("rst_mid_cnt", stall_cycles, 32'd0);
    e_md_is_div = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_hold_done", {31'd0, md_done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("post_rst_idle", {31'd0, md_busy}, 32'd0);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      e_md_start = (i < 5);
      #1;
      check_eq($sformatf("pr_mul_busy%0d", i), {31'd0, md_busy}, (i <= 4) ? 32'd1 : 32'd0);
      check_eq($sformatf("pr_mul_done%0d", i), {31'd0, md_done}, (i == 4) ? 32'd1 : 32'd0);
    end
    check_eq("pr_cnt", stall_cycles, 32'd4);
    check_eq("pr_cnt_wrap", x_stall_cycles, 32'd2);
    @(negedge clk);
    #1;
    check_eq("pr_idle", {31'd0, md_busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
